// File: rtl/otg_hpi_bus_ctrl_if.sv
// Avalon-MM slave bundle between the Nios II data master and the HPI bus sequencer.
interface otg_hpi_bus_ctrl_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/otg_hpi_bus_ctrl.sv
// Sequences Avalon accesses into timed HPI setup/strobe/hold/recover cycles.
// Define OTG_HPI_INT_SYNC_EN to synchronize hpi_int into a sticky irq cleared by a STATUS read.
module otg_hpi_bus_ctrl #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 4,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned RECOVER_CYC = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    otg_hpi_bus_ctrl_if.slave bus,
    output logic [1:0]        o_hpi_addr,
    output logic              o_hpi_cs_n,
    output logic              o_hpi_rd_n,
    output logic              o_hpi_wr_n,
    output logic [15:0]       o_hpi_data_out,
    output logic              o_hpi_data_oe,
    input  logic [15:0]       i_hpi_data_in,
    input  logic              i_hpi_int,
    output logic              o_irq
);

    localparam logic [3:0] L_SETUP   = 4'(SETUP_CYC - 1);
    localparam logic [3:0] L_STROBE  = 4'(STROBE_CYC - 1);
    localparam logic [3:0] L_HOLD    = 4'(HOLD_CYC - 1);
    localparam logic [3:0] L_RECOVER = 4'(RECOVER_CYC - 1);

    typedef enum logic [2:0] {
        StIdle, StSetup, StStrobe, StHold, StDone, StRecover
    } state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_d;
    logic        r_write;
    logic        w_accept;
    logic        w_write_d;
    logic        w_cs_n_d;
    logic        w_rd_n_d;
    logic        w_wr_n_d;
    logic        w_oe_d;
    logic        w_wait_d;
    logic        w_capture;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Each state is entered with its length minus one and left when the counter hits zero.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_accept  = 1'b0;
        if (r_state == StIdle) begin
            if (bus.read || bus.write) begin
                w_accept  = 1'b1;
                w_state_d = StSetup;
                w_cnt_d   = L_SETUP;
            end
        end else if (r_cnt != 4'd0) begin
            w_cnt_d = r_cnt - 4'd1;
        end else begin
            case (r_state)
                StSetup: begin
                    w_state_d = StStrobe;
                    w_cnt_d   = L_STROBE;
                end
                StStrobe: begin
                    w_state_d = StHold;
                    w_cnt_d   = L_HOLD;
                end
                StHold: begin
                    w_state_d = StDone;
                    w_cnt_d   = 4'd0;
                end
                StDone: begin
                    w_state_d = StRecover;
                    w_cnt_d   = L_RECOVER;
                end
                default: begin
                    w_state_d = StIdle;
                    w_cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Pin values are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        w_write_d = w_accept ? bus.write : r_write;
        w_cs_n_d  = !((w_state_d == StSetup) || (w_state_d == StStrobe) || (w_state_d == StHold));
        w_rd_n_d  = !((w_state_d == StStrobe) && !w_write_d);
        w_wr_n_d  = !((w_state_d == StStrobe) && w_write_d);
        w_oe_d    = !w_cs_n_d && w_write_d;
        w_wait_d  = (w_state_d != StDone);
        w_capture = (r_state == StStrobe) && (r_cnt == 4'd0) && !r_write;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_hpi_cs_n      <= 1'b1;
            o_hpi_rd_n      <= 1'b1;
            o_hpi_wr_n      <= 1'b1;
            o_hpi_data_oe   <= 1'b0;
            o_hpi_addr      <= 2'd0;
            o_hpi_data_out  <= 16'd0;
            bus.waitrequest <= 1'b1;
            bus.readdata    <= 16'd0;
            r_write         <= 1'b0;
        end else begin
            o_hpi_cs_n      <= w_cs_n_d;
            o_hpi_rd_n      <= w_rd_n_d;
            o_hpi_wr_n      <= w_wr_n_d;
            o_hpi_data_oe   <= w_oe_d;
            bus.waitrequest <= w_wait_d;
            if (w_accept) begin
                r_write        <= bus.write;
                o_hpi_addr     <= bus.address;
                o_hpi_data_out <= bus.writedata;
            end
            if (w_capture) begin
                bus.readdata <= i_hpi_data_in;
            end
        end
    end

`ifdef OTG_HPI_INT_SYNC_EN
    logic r_int_s1;
    logic r_int_s2;
    logic r_int_s3;
    logic r_irq;
    logic w_rise;
    logic w_status_rd;

    assign w_rise      = r_int_s2 && !r_int_s3;
    assign w_status_rd = (r_state == StDone) && !r_write && (o_hpi_addr == 2'd3);

    // A rising edge coinciding with the STATUS read wins over the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_int_s1 <= 1'b0;
            r_int_s2 <= 1'b0;
            r_int_s3 <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_int_s1 <= i_hpi_int;
            r_int_s2 <= r_int_s1;
            r_int_s3 <= r_int_s2;
            if (w_rise) begin
                r_irq <= 1'b1;
            end else if (w_status_rd) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign o_irq = r_irq;
`else
    assign o_irq = i_hpi_int;
`endif

endmodule

// File: tb/tb_otg_hpi_bus_ctrl.sv
// Bench for otg_hpi_bus_ctrl: cycle-phase reference model, per-cycle compare, directed and random accesses.
module tb_otg_hpi_bus_ctrl;

    localparam int S  = 1;
    localparam int ST = 4;
    localparam int H  = 1;
    localparam int R  = 2;
    localparam int T  = S + ST + H + 1;   // DONE phase, counted from the accepting cycle

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  hpi_addr;
    logic        hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_data_oe, hpi_int, irq;
    logic [15:0] hpi_data_out, hpi_data_in;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    otg_hpi_bus_ctrl_if bus ();

    otg_hpi_bus_ctrl #(
        .SETUP_CYC  (S),
        .STROBE_CYC (ST),
        .HOLD_CYC   (H),
        .RECOVER_CYC(R)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .o_hpi_addr    (hpi_addr),
        .o_hpi_cs_n    (hpi_cs_n),
        .o_hpi_rd_n    (hpi_rd_n),
        .o_hpi_wr_n    (hpi_wr_n),
        .o_hpi_data_out(hpi_data_out),
        .o_hpi_data_oe (hpi_data_oe),
        .i_hpi_data_in (hpi_data_in),
        .i_hpi_int     (hpi_int),
        .o_irq         (irq)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_phase counts cycles since the accepting cycle (0 = idle/accepting).
    int          m_phase;
    logic        m_write;
    logic [1:0]  m_addr;
    logic [15:0] m_data, m_rdata;
    logic [2:0]  m_hist;
    logic        m_irq;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0;
            m_write <= 1'b0;
            m_addr  <= 2'd0;
            m_data  <= 16'd0;
            m_rdata <= 16'd0;
            m_hist  <= 3'd0;
            m_irq   <= 1'b0;
        end else begin
            m_hist <= {m_hist[1:0], hpi_int};
            if (m_hist[1] && !m_hist[2])
                m_irq <= 1'b1;
            else if (m_phase == T && !m_write && m_addr == 2'd3)
                m_irq <= 1'b0;
            if (m_phase == 0) begin
                if (bus.read || bus.write) begin
                    m_phase <= 1;
                    m_write <= bus.write;
                    m_addr  <= bus.address;
                    m_data  <= bus.writedata;
                end
            end else begin
                if (m_phase == S + ST && !m_write) m_rdata <= hpi_data_in;
                m_phase <= (m_phase == T + R) ? 0 : m_phase + 1;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic cs_act, strb;
        if (reset_n) begin
            cs_act = (m_phase >= 1) && (m_phase <= S + ST + H);
            strb   = (m_phase > S) && (m_phase <= S + ST);
            check("cs_n", 16'(hpi_cs_n), 16'(!cs_act));
            check("rd_n", 16'(hpi_rd_n), 16'(!(strb && !m_write)));
            check("wr_n", 16'(hpi_wr_n), 16'(!(strb && m_write)));
            check("oe", 16'(hpi_data_oe), 16'(cs_act && m_write));
            check("waitrequest", 16'(bus.waitrequest), 16'(m_phase != T));
            check("readdata", bus.readdata, m_rdata);
            if (cs_act) check("hpi_addr", 16'(hpi_addr), 16'(m_addr));
            if (cs_act && m_write) check("data_out", hpi_data_out, m_data);
`ifdef OTG_HPI_INT_SYNC_EN
            check("irq", 16'(irq), 16'(m_irq));
`else
            check("irq", 16'(irq), 16'(hpi_int));
`endif
        end
    end

    logic [39:0] rec_cs, rec_rd, rec_wr, rec_oe, rec_wait;
    logic [15:0] rec_rdata;

    // Called at posedge+2; holds the request until waitrequest is seen low, returns at posedge+2.
    task automatic access(input bit wr, input bit rd, input logic [1:0] a, input logic [15:0] d,
                          input bit rnd, output int lat);
        bit done = 1'b0;
        bit acc  = 1'b0;
        lat = -1;
        rec_cs = '1; rec_rd = '1; rec_wr = '1; rec_oe = '0; rec_wait = '1;
        bus.write = wr; bus.read = rd; bus.address = a; bus.writedata = d;
        if (!rnd) hpi_data_in = d;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            rec_cs[k] = hpi_cs_n; rec_rd[k] = hpi_rd_n; rec_wr[k] = hpi_wr_n;
            rec_oe[k] = hpi_data_oe; rec_wait[k] = bus.waitrequest;
            if (!hpi_cs_n) acc = 1'b1;
            if (!bus.waitrequest) begin
                done = 1'b1;
                lat = k;
                rec_rdata = bus.readdata;
            end
            @(posedge clk); #2;
            if (done) break;
            if (rnd) begin
                hpi_data_in = 16'($urandom);
                hpi_int = 1'($urandom);
                if (acc) begin
                    bus.address = 2'($urandom);
                    bus.writedata = 16'($urandom);
                end
            end else begin
                hpi_data_in = (k + 1 <= S + ST) ? d : 16'h0000;
            end
        end
        bus.write = 1'b0;
        bus.read = 1'b0;
        check("access completed", 16'(done), 16'd1);
    endtask

    initial begin
        int lat, first_low;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = 2'd0; bus.writedata = 16'd0;
        hpi_data_in = 16'd0; hpi_int = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset cs_n", 16'(hpi_cs_n), 16'd1);
        check("reset rd_n", 16'(hpi_rd_n), 16'd1);
        check("reset wr_n", 16'(hpi_wr_n), 16'd1);
        check("reset waitrequest", 16'(bus.waitrequest), 16'd1);
        check("reset oe", 16'(hpi_data_oe), 16'd0);
        check("reset addr", 16'(hpi_addr), 16'd0);
        check("reset data_out", hpi_data_out, 16'd0);
        check("reset readdata", bus.readdata, 16'd0);
        check("reset irq", 16'(irq), 16'd0);
        reset_n = 1'b1;
        @(posedge clk); #2;

        // Write addr 2: cs_n low 1..6, wr_n low 2..5, waitrequest low at 7.
        access(1'b1, 1'b0, 2'd2, 16'h1234, 1'b0, lat);
        check("write latency", 16'(lat), 16'd7);
        check("write cs_n pattern", 16'(rec_cs[7:0]), 16'h0081);
        check("write wr_n pattern", 16'(rec_wr[7:0]), 16'h00C3);
        check("write rd_n pattern", 16'(rec_rd[7:0]), 16'h00FF);
        check("write oe pattern", 16'(rec_oe[7:0]), 16'h007E);
        check("write wait pattern", 16'(rec_wait[7:0]), 16'h007F);
        repeat (4) @(posedge clk);
        #2;

        // Read addr 0: pad shows BEEF in STROBE, 0000 in HOLD.
        access(1'b0, 1'b1, 2'd0, 16'hBEEF, 1'b0, lat);
        check("read latency", 16'(lat), 16'd7);
        check("read readdata at DONE", rec_rdata, 16'hBEEF);
        check("read rd_n pattern", 16'(rec_rd[7:0]), 16'h00C3);
        check("read oe pattern", 16'(rec_oe[7:0]), 16'h0000);
        repeat (4) @(posedge clk);
        #2;

        // read and write together: write wins, readdata untouched.
        access(1'b1, 1'b1, 2'd1, 16'hA5A5, 1'b0, lat);
        check("both wr_n pattern", 16'(rec_wr[7:0]), 16'h00C3);
        check("both rd_n pattern", 16'(rec_rd[7:0]), 16'h00FF);
        check("both readdata kept", rec_rdata, 16'hBEEF);
        repeat (4) @(posedge clk);
        #2;

        // Back-to-back: DONE ends at the edge starting k=0; cs_n falls R+1 edges later.
        access(1'b1, 1'b0, 2'd2, 16'h1111, 1'b0, lat);
        access(1'b1, 1'b0, 2'd3, 16'h2222, 1'b0, lat);
        first_low = -1;
        for (int k = 39; k >= 0; k--) if (!rec_cs[k]) first_low = k;
        check("b2b cs_n fall offset", 16'(first_low), 16'(R + 1));
        check("b2b latency", 16'(lat), 16'(R + 1 + T - 1));
        repeat (4) @(posedge clk);
        #2;

        // Reset during STROBE.
        bus.write = 1'b1; bus.address = 2'd1; bus.writedata = 16'h5555;
        repeat (4) @(negedge clk);
        check("pre-reset wr_n in strobe", 16'(hpi_wr_n), 16'd0);
        #1 reset_n = 1'b0;
        #1;
        check("mid reset cs_n", 16'(hpi_cs_n), 16'd1);
        check("mid reset wr_n", 16'(hpi_wr_n), 16'd1);
        check("mid reset rd_n", 16'(hpi_rd_n), 16'd1);
        check("mid reset waitrequest", 16'(bus.waitrequest), 16'd1);
        check("mid reset oe", 16'(hpi_data_oe), 16'd0);
        bus.write = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #2;
        access(1'b1, 1'b0, 2'd3, 16'h0F0F, 1'b0, lat);
        check("post-reset latency", 16'(lat), 16'd7);
        repeat (4) @(posedge clk);
        #2;

`ifdef OTG_HPI_INT_SYNC_EN
        hpi_int = 1'b1;
        @(posedge clk); #2;
        hpi_int = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("irq after pulse", 16'(irq), 16'(k >= 3));
        end
        @(posedge clk); #2;
        access(1'b0, 1'b1, 2'd3, 16'h0000, 1'b0, lat);
        @(negedge clk);
        check("irq cleared by STATUS read", 16'(irq), 16'd0);
        @(posedge clk); #2;
`else
        hpi_int = 1'b1;
        #1 check("irq follows hpi_int high", 16'(irq), 16'd1);
        hpi_int = 1'b0;
        #1 check("irq follows hpi_int low", 16'(irq), 16'd0);
        @(posedge clk); #2;
`endif

        for (int n = 0; n < 150; n++) begin
            int gap;
            bit wr, rd;
            gap = int'($urandom_range(0, 3));
            repeat (gap) begin
                hpi_data_in = 16'($urandom);
                hpi_int = 1'($urandom);
                bus.address = 2'($urandom);
                bus.writedata = 16'($urandom);
                @(posedge clk); #2;
            end
            wr = 1'($urandom);
            rd = !wr || ($urandom_range(0, 3) == 0);
            access(wr, rd, 2'($urandom), 16'($urandom), 1'b1, lat);
        end
        repeat (6) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
